// File: rtl/delay_pkg.sv
// Shared package for the variable-delay controller and its FIFO.
// Holds the default delay-count width and a ceil(log2) helper.
package delay_pkg;

  // Width of the delay counter; the FIFO depth is 2**DEFAULT_DELAY_CNT_WIDTH.
  localparam int DEFAULT_DELAY_CNT_WIDTH = 32'd7;

  // Number of address bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int res;
    int v;
    res = 32'd0;
    v   = value - 32'd1;
    while (v > 32'sd0) begin
      res = res + 32'd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_line_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port and one synchronous read port with an
// output register. Storage has no reset so it maps onto block RAM; only the
// output register is cleared by reset.
module sdp_ram
  import delay_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = clogb2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  dout_o
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] dout_q;

  // Write port: store the word at the write address when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= din_i;
    end
  end

  // Read port: output register loads on a read and holds otherwise.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      dout_q <= '0;
    end else if (re_i) begin
      dout_q <= mem_q[raddr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/delay_line_fifo.sv
// Single-clock FIFO for the variable-delay controller. Pointers, occupancy
// counter, status flags and error pulses live here; data storage and the
// registered read data come from the sdp_ram instance.
module delay_line_fifo
  import delay_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int DEPTH_LOG2     = DEFAULT_DELAY_CNT_WIDTH,
  parameter int ALMOST_FULL_TH = 120
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [WIDTH-1:0]      DIN,
  input  logic                  WE,
  input  logic                  RE,
  output logic [WIDTH-1:0]      DOUT,
  output logic                  NOT_EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [DEPTH_LOG2:0]   DATA_COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_TH_C = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          not_empty_q, full_q, almost_full_q;
  logic          overflow_q, underflow_q;
  logic          wr_acc_s, rd_acc_s;

  // Accept decisions use only the registered flags, so a write at FULL is
  // dropped even when a read happens in the same cycle.
  always_comb begin
    wr_acc_s = WE & ~full_q;
    rd_acc_s = RE & not_empty_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc_s);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc_s);
    count_d  = count_q + PW'(wr_acc_s) - PW'(rd_acc_s);
  end

  // Pointer, occupancy, flag and error-pulse registers; flags derive from the
  // next count so they move on the same edge as DATA_COUNT.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      not_empty_q   <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      not_empty_q   <= (count_d != '0);
      full_q        <= (count_d == DEPTH_C);
      almost_full_q <= (count_d >= AF_TH_C);
      overflow_q    <= WE & full_q;
      underflow_q   <= RE & ~not_empty_q;
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (CLK),
    .resetn_i (RESETN),
    .we_i     (wr_acc_s),
    .waddr_i  (wr_ptr_q[DEPTH_LOG2-1:0]),
    .din_i    (DIN),
    .re_i     (rd_acc_s),
    .raddr_i  (rd_ptr_q[DEPTH_LOG2-1:0]),
    .dout_o   (DOUT)
  );

  assign NOT_EMPTY   = not_empty_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = almost_full_q;
  assign DATA_COUNT  = count_q;
  assign OVERFLOW    = overflow_q;
  assign UNDERFLOW   = underflow_q;

endmodule
